// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// the low-word constant returned on a divide by zero.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_t;

    localparam logic [31:0] MDU_DZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the unit: radix-2 shift-add for multiply, restoring
// shift-subtract for divide. Purely combinational.
//   multiply: acc = {partial product hi, multiplier bits still to consume}
//   divide:   acc = {partial remainder, dividend bits / quotient bits}
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic [1:0]         op,
    output logic [2*WIDTH-1:0] acc_next
);

    logic              is_div;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    diff;

    assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);

    // Multiply adds the multiplicand when the current multiplier bit is set and
    // shifts the carry in; divide shifts the next dividend bit into a 33-bit
    // remainder so the top dividend bit of divu is never lost.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, operand};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS mult/multu/div/divu unit producing {hi,lo}. Operands are
// reduced to magnitudes at launch, iterated for ITERS cycles, and the signs
// are reapplied in a single fix-up cycle before prod is registered.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CNT_W = $clog2(ITERS);

    mdu_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd;
    logic [1:0]         op_r;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic               launch_signed;
    logic               launch_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] result;

    function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v) + WIDTH'(1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_dword(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v) + (2*WIDTH)'(1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        return neg_word(v, v < 0);
    endfunction

    assign launch_signed = !((op == MDU_MULTU) || (op == MDU_DIVU));
    assign launch_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    assign a_mag         = launch_signed ? abs_val($signed(src_a)) : src_a;
    assign b_mag         = launch_signed ? abs_val($signed(src_b)) : src_b;

    mdu_iter_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .acc      (acc),
        .operand  (opnd),
        .op       (op_r),
        .acc_next (acc_next)
    );

    // Sign fix-up of the raw magnitude result; divide-by-zero passes through untouched.
    always_comb begin
        if (dz) begin
            result = acc;
        end else if (op_r == MDU_DIV || op_r == MDU_DIVU) begin
            result = {neg_word(acc[2*WIDTH-1:WIDTH], neg_r), neg_word(acc[WIDTH-1:0], neg_q)};
        end else begin
            result = neg_dword(acc, neg_q);
        end
    end

    // Control FSM: launch in IDLE, iterate in CALC, fix signs and publish in FIX.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            prod  <= '0;
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            op_r  <= MDU_MULT;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !cancel) begin
                        op_r  <= op;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        neg_q <= launch_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_r <= launch_signed & src_a[WIDTH-1];
                        if (launch_div && (src_b == '0)) begin
                            dz    <= 1'b1;
                            acc   <= {src_a, WIDTH'(MDU_DZ_LO)};
                            opnd  <= '0;
                            state <= S_FIX;
                        end else if (launch_div) begin
                            dz    <= 1'b0;
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            opnd  <= b_mag;
                            state <= S_CALC;
                        end else begin
                            dz    <= 1'b0;
                            acc   <= {{WIDTH{1'b0}}, b_mag};
                            opnd  <= a_mag;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(ITERS - 1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (!cancel) begin
                        prod <= result;
                        done <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal results,
// randomized operations, and a cycle-level behavioural model of busy/done/prod.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic [63:0] prod;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_pending = '0;
    int          m_rem = 0;

    mult_div_unit #(
        .WIDTH (32),
        .ITERS (32)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .prod   (prod)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // MIPS semantics computed directly with 64-bit arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT:  res = 64'(sa * sb);
            OP_MULTU: res = {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Model: an accepted op finishes 33 edges later (1 for divide by zero)
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (cancel) begin
                    m_busy <= 1'b0;
                end else if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_prod <= m_pending;
                end else begin
                    m_rem <= m_rem - 1;
                end
            end else if (start && !cancel) begin
                m_busy    <= 1'b1;
                m_pending <= ref_result(op, src_a, src_b);
                m_rem     <= (op[1] && src_b == 0) ? 1 : 33;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the clock edge
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("model_busy", 64'(busy), 64'(m_busy));
            chk("model_done", 64'(done), 64'(m_done));
            chk("model_prod", prod, m_prod);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                          input int intrude_at);
        int lat;
        int bcnt;
        bit got;
        op = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        lat = 0;
        got = 1'b0;
        bcnt = busy ? 1 : 0;
        while (!got && lat < 40) begin
            if (lat == intrude_at) begin
                start = 1'b1;
                op = OP_MULT;
                src_a = 32'd3;
                src_b = 32'd3;
            end
            tick();
            start = 1'b0;
            lat++;
            if (done) got = 1'b1;
            else if (busy) bcnt++;
        end
        chk({name, "_done_seen"}, 64'(got), 64'd1);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
        chk({name, "_prod"}, prod, exp);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_prod", prod, 64'd0);
        reset = 1'b1;
        cmp_en = 1'b1;
        tick();

        run_op("mult_7x6", OP_MULT, 32'd7, 32'd6, 64'h0000_0000_0000_002A, 33, -1);
        run_op("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 33, -1);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, -1);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, -1);
        run_op("divu_max_16", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 64'h0000_000F_0FFF_FFFF, 33, -1);
        run_op("div_by_zero", OP_DIV, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1, -1);
        run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, -1);

        // cancel during iteration 10 of mult 5 x 5
        op = OP_MULT;
        src_a = 32'd5;
        src_b = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_done", 64'(done), 64'd0);
        chk("cancel_prod", prod, 64'h0000_0000_8000_0000);
        tick();
        run_op("mult_5x5_after_cancel", OP_MULT, 32'd5, 32'd5, 64'd25, 33, -1);

        // start and cancel on the same idle edge
        start = 1'b1;
        cancel = 1'b1;
        tick();
        start = 1'b0;
        cancel = 1'b0;
        chk("start_cancel_busy", 64'(busy), 64'd0);
        tick();

        // asynchronous reset in the middle of a divide
        op = OP_DIV;
        src_a = 32'd1000;
        src_b = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        reset = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_prod", prod, 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // start while busy is ignored
        run_op("div_with_intruder", OP_DIV, 32'd1000, 32'd7, 64'h0000_0006_0000_008E, 33, 5);

        // randomized operations with occasional cancels and ignored starts
        for (int i = 0; i < 60; i++) begin
            int sel;
            int cyc;
            int cancel_at;
            sel = $urandom_range(0, 7);
            op = 2'($urandom_range(0, 3));
            src_a = $urandom;
            src_b = $urandom;
            case (sel)
                0: src_b = 32'd0;
                1: begin src_a = 32'h8000_0000; src_b = 32'hFFFF_FFFF; end
                2: begin src_a = $urandom_range(0, 20); src_b = $urandom_range(0, 20); end
                3: src_a = 32'h8000_0000;
                default: ;
            endcase
            start = 1'b1;
            tick();
            start = 1'b0;
            cancel_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 34)) : -1;
            cyc = 0;
            while (busy && cyc < 40) begin
                if (cyc == cancel_at) cancel = 1'b1;
                if ($urandom_range(0, 15) == 0) start = 1'b1;
                op = 2'($urandom_range(0, 3));
                src_a = $urandom;
                src_b = $urandom;
                tick();
                cancel = 1'b0;
                start = 1'b0;
                cyc++;
            end
            chk("rand_finished", 64'(busy), 64'd0);
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
